// File: rtl/c432_resp_misr.sv
// Compacts c432 response words into a 16-bit MISR and compares the result against a golden signature.
// Optional build macro C432_RESP_MASK_EN adds a resp_mask input that zeroes selected response bits.
module c432_resp_misr #(
  parameter int          CNT_W = 36,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pat,
  input  logic             resp_valid,
  input  logic [6:0]       resp,
`ifdef C432_RESP_MASK_EN
  input  logic [6:0]       resp_mask,
`endif
  output logic             resp_ready,
  input  logic [15:0]      golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] pat_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [15:0]      sig_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] num_pat_q;
  logic             done_q;
  logic             pass_q;

  logic [6:0]       resp_eff;
  logic [15:0]      sig_d;
  logic [CNT_W-1:0] cnt_d;
  logic             xfer;
  logic             last_xfer;

`ifdef C432_RESP_MASK_EN
  assign resp_eff = resp & ~resp_mask;
`else
  assign resp_eff = resp;
`endif

  // Galois-style shift with CCITT polynomial, then fold in the response word.
  assign sig_d     = ((sig_q << 1) ^ (sig_q[15] ? 16'h1021 : 16'h0000)) ^ {9'b0, resp_eff};
  assign cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign xfer      = resp_valid && (state_q == RUN);
  assign last_xfer = (cnt_q == (num_pat_q - {{(CNT_W-1){1'b0}}, 1'b1}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sig_q     <= SEED;
      cnt_q     <= '0;
      num_pat_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // start takes priority over any response offered in the same cycle
          if (start) begin
            sig_q     <= SEED;
            cnt_q     <= '0;
            num_pat_q <= num_pat;
            if (num_pat == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= (SEED == golden);
            end else begin
              state_q <= RUN;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (last_xfer) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == golden);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q == RUN);
  assign resp_ready = (state_q == RUN);
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign pat_cnt    = cnt_q;

endmodule
